// File: rtl/mem_pkg.sv
// Shared types for the data memory responder.
//   size_e  : transfer size encoding on req_size
//   state_e : responder FSM states
//   req_t   : captured request fields
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory, shared by the load and store paths.
//   size, addr_lo, is_unsigned : request attributes
//   wdata      : right-justified store data
//   rdata      : raw stored word at the addressed location
//   wlanes     : store data replicated onto the lanes it may occupy
//   byte_en    : lanes written by a store (0 for an illegal size)
//   rdata_ext  : selected load lane(s), zero- or sign-extended
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wlanes,
  output logic [3:0]  byte_en,
  output logic [31:0] rdata_ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    wlanes    = '0;
    byte_en   = '0;
    rdata_ext = '0;
    sel_byte  = rdata[{addr_lo, 3'b000} +: 8];
    sel_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (size)
      SZ_BYTE: begin
        wlanes    = {4{wdata[7:0]}};
        byte_en   = 4'b0001 << addr_lo;
        rdata_ext = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        wlanes    = {2{wdata[15:0]}};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        rdata_ext = {{16{~is_unsigned & sel_half[15]}}, sel_half};
      end
      SZ_WORD: begin
        wlanes    = wdata;
        byte_en   = 4'b1111;
        rdata_ext = rdata;
      end
      default: begin
        wlanes    = '0;
        byte_en   = '0;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed response latency.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   req_*               : request channel (valid/ready), byte address, sized access
//   rsp_*               : response channel (valid/ready), extended load data, error flag
// The memory is accessed on the edge that enters RESP; responses are held until rsp_ready.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d, req_in, acc_req;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic            do_access;
  logic            mem_we;
  logic            acc_err;
  logic [IdxW-1:0] word_idx;
  logic [31:0]     rd_word;
  logic [31:0]     wlanes;
  logic [3:0]      byte_en;
  logic [31:0]     rdata_ext;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_in = '{
    write:       req_write,
    size:        size_e'(req_size),
    is_unsigned: req_unsigned,
    addr:        req_addr,
    wdata:       req_wdata
  };

  // With LATENCY = 1 the access happens on the accept edge itself, before capture.
  assign acc_req  = (state_q == StIdle) ? req_in : req_q;
  assign word_idx = acc_req.addr[IdxW+1:2];
  assign rd_word  = mem[word_idx];

  assign acc_err = (acc_req.size == SZ_ILLEGAL) ||
                   (acc_req.size == SZ_HALF && acc_req.addr[0]) ||
                   (acc_req.size == SZ_WORD && acc_req.addr[1:0] != 2'b00) ||
                   ({2'b00, acc_req.addr[31:2]} >= 32'(DEPTH_WORDS));

  mem_lane_align u_lane_align (
    .size        (acc_req.size),
    .addr_lo     (acc_req.addr[1:0]),
    .is_unsigned (acc_req.is_unsigned),
    .wdata       (acc_req.wdata),
    .rdata       (rd_word),
    .wlanes      (wlanes),
    .byte_en     (byte_en),
    .rdata_ext   (rdata_ext)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    valid_d   = valid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          req_d = req_in;
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d   = StResp;
            do_access = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = StResp;
          do_access = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_access) begin
      valid_d = 1'b1;
      err_d   = acc_err;
      rdata_d = (acc_err || acc_req.write) ? 32'h0 : rdata_ext;
      mem_we  = !acc_err && acc_req.write;
    end

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; a reset in BUSY leaves state at IDLE so no write fires.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
